sti_pixel_packer: RTL and testbench
===================================

# sti_pixel_packer

Parametrised serial-transmit and pixel-pack engine. It accepts words of configurable length from the host, serialises them MSB- or LSB-first on `so_data`/`so_valid`, and packs the same bit stream into PW-bit pixels that it writes sequentially into a 2**AW-entry pixel memory. On end of stream it flushes any partial pixel, fills the remaining memory with a constant, and raises a sticky finish flag. It is the next generation of the block that sits between the host serial interface and the frame memory, adding a busy handshake, partial-pixel flush and single-cycle fill.

## Interface
- DW, 16: host data width; must be even, at least 2.
- PW, 8: pixel width; 1 ≤ PW ≤ 2*DW.
- AW, 8: pixel address width; memory depth is 2**AW.
- FILL, 0: PW-bit value written to unwritten pixels after end of stream.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  word-valid strobe; accepted only when busy=0 and in IDLE.
- pi_data  input  DW  host word.
- pi_length  input  2  word length L: 00=DW/2, 01=DW, 10=3DW/2, 11=2DW.
- pi_fill  input  1  for lengths 10/11: 1=data left-aligned, 0=right-aligned.
- pi_msb  input  1  1=serialise MSB first, 0=LSB first.
- pi_low  input  1  for length 00: 1=upper half of pi_data, 0=lower half.
- pi_end  input  1  end of stream; sampled only in IDLE; has priority over load.
- busy  output  1  high whenever state≠IDLE.
- so_data  output  1  serial data bit.
- so_valid  output  1  so_data qualifier.
- pixel_wr  output  1  one-cycle pixel write strobe.
- pixel_addr  output  AW  write address.
- pixel_dataout  output  PW  write data.
- pixel_finish  output  1  sticky completion flag.

## Operation
- States: IDLE, SHIFT, FLUSH, FILL, DONE.
- IDLE:
  - pi_end=1 goes to FLUSH if the accumulator holds a partial pixel, otherwise to FILL.
  - Otherwise load=1 latches the frame and goes to SHIFT.
- Frame formation at load:
  - 00: W = selected DW/2-bit half.
  - 01: W = pi_data.
  - 10: W = pi_fill ? {pi_data, DW/2 zeros} : {DW/2 zeros, pi_data}.
  - 11: W = pi_fill ? {pi_data, DW zeros} : {DW zeros, pi_data}.
- SHIFT: emits L bits of W, in order W[L-1]..W[0] if pi_msb=1, otherwise W[0]..W[L-1]. pi_msb is latched at load. After the last bit the state returns to IDLE.
- Pixel packing:
  - Each emitted bit shifts into the accumulator LSB-side; the first bit of a pixel ends up at pixel_dataout[PW-1].
  - The bit count persists across words; leftover bits carry into the next word.
  - On the PW-th bit, the full pixel is written and the count clears.
- FLUSH: writes the partial pixel left-aligned and zero-padded (k bits → {bits, PW-k zeros}) at pixel_addr, then goes to FILL, or to DONE if that write was address 2**AW-1.
- FILL: writes FILL once per cycle at successive addresses through 2**AW-1, then goes to DONE.
- pixel_addr increments by 1 in the cycle after each write, modulo 2**AW.
- Any write to address 2**AW-1 forces DONE, from SHIFT too; the rest of the current word is discarded.
- DONE: load and pi_end are ignored and pixel_finish=1. Only reset exits DONE.

## Timing
- Reset (asynchronous, no clock needed): state=IDLE; accumulator and count cleared; all outputs 0, including pixel_addr and pixel_finish.
- Load accepted at edge e0. Cycles 1..L carry so_valid=1 and bit i-1 of the emission order, with busy=1. Cycle L+1 has busy=0 and so_valid=0.
- Next load is accepted at the edge ending cycle L+1. With load held high, word throughput is one per L+1 cycles.
- load while busy=1 is ignored; there is no queue.
- pixel_wr=1 in the same cycle as so_valid for the completing bit; pixel_dataout holds the complete pixel and pixel_addr its address.
- so_valid=0 in every cycle outside SHIFT output.
- pixel_dataout holds its value when pixel_wr=0.
- pi_end accepted at e0:
  - FLUSH write in cycle 1 if applicable.
  - FILL writes in consecutive cycles.
  - pixel_finish rises the cycle after the write to 2**AW-1 and stays high.
- Simultaneous load and pi_end in IDLE: pi_end wins and load is dropped.

## Test plan
- DW=16, PW=8: load pi_length=01, pi_data=16'hA53C, pi_msb=1 -> so_data 1010010100111100 over 16 cycles; pixel_wr at cycles 8 and 16 with addr0=8'hA5 and addr1=8'h3C; busy=0 at cycle 17.
- pi_length=00, pi_low=1, pi_data=16'h13FF, pi_msb=0 -> bits 1,1,0,0,1,0,0,0; pixel 8'hC8 written.
- pi_length=10, pi_data=16'hFFFF, pi_msb=1: pi_fill=0 -> pixels 00,FF,FF; pi_fill=1 -> pixels FF,FF,00.
- load held high for two words -> second so_valid burst starts exactly L+1 cycles after the first. load pulsed mid-word -> ignored, and so_valid count equals L.
- DW=12, PW=8: load 12'hFC0, length 00, pi_low=1, then pi_end -> addr0=8'hFC (flush), FILL at addr 1..255 on consecutive cycles, pixel_finish the cycle after addr 255; later load ignored.
- Reset asserted mid-SHIFT without a clock edge -> all outputs 0 immediately. Separately, 128 words of 16 bits with no pi_end -> pixel_finish after the addr-255 write.

Source files
------------

// File: rtl/sti_pixel_packer.sv
// sti_pixel_packer
// Serialises host words (DW/2, DW, 3DW/2 or 2DW bits, MSB- or LSB-first) onto
// so_data/so_valid and packs the same bit stream into PW-bit pixels written
// sequentially into a 2**AW-entry pixel memory. On end of stream any partial
// pixel is flushed left-aligned, the rest of the memory is filled with FILL,
// and pixel_finish is raised until reset.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   load                 word strobe, taken only in IDLE
//   pi_data[DW]          host word
//   pi_length[2]         00=DW/2, 01=DW, 10=3DW/2, 11=2DW bits
//   pi_fill              lengths 10/11: 1=left-aligned, 0=right-aligned
//   pi_msb               1=MSB first, 0=LSB first
//   pi_low               length 00: 1=upper half, 0=lower half
//   pi_end               end of stream (IDLE only, wins over load)
//   busy                 state is not IDLE
//   so_data, so_valid    serial output
//   pixel_wr, pixel_addr[AW], pixel_dataout[PW]   pixel memory write port
//   pixel_finish         sticky completion flag
module sti_pixel_packer #(
  parameter int unsigned   DW   = 16,
  parameter int unsigned   PW   = 8,
  parameter int unsigned   AW   = 8,
  parameter logic [PW-1:0] FILL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] pi_data,
  input  logic [1:0]    pi_length,
  input  logic          pi_fill,
  input  logic          pi_msb,
  input  logic          pi_low,
  input  logic          pi_end,
  output logic          busy,
  output logic          so_data,
  output logic          so_valid,
  output logic          pixel_wr,
  output logic [AW-1:0] pixel_addr,
  output logic [PW-1:0] pixel_dataout,
  output logic          pixel_finish
);

  localparam int unsigned FW = 2 * DW;
  localparam int unsigned HW = DW / 2;
  localparam int unsigned LW = $clog2(FW + 1);
  localparam int unsigned CW = $clog2(PW + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_FLUSH, ST_FILL, ST_DONE} state_t;

  state_t        state;
  logic [FW-1:0] sr;
  logic          msb_first;
  logic [LW-1:0] remaining;
  logic [PW-1:0] acc;
  logic [CW-1:0] cnt;

  logic [FW-1:0] frame;
  logic [FW-1:0] frame_sr;
  logic [FW-1:0] cur_sr;
  logic [FW-1:0] next_sr;
  logic [LW-1:0] frame_len;
  logic          cur_msb;
  logic          bit_out;
  logic          emit;
  logic [PW-1:0] acc_next;
  logic [PW-1:0] flush_pix;
  logic          pix_full;
  logic [AW-1:0] wr_addr;
  logic          wr_last;

  assign busy = (state != ST_IDLE);

  always_comb begin
    frame     = '0;
    frame_len = LW'(DW);
    case (pi_length)
      2'b00: begin
        frame[HW-1:0] = pi_low ? pi_data[DW-1:HW] : pi_data[HW-1:0];
        frame_len     = LW'(HW);
      end
      2'b01: frame[DW-1:0] = pi_data;
      2'b10: begin
        frame[DW+HW-1:0] = pi_fill ? {pi_data, {HW{1'b0}}} : {{HW{1'b0}}, pi_data};
        frame_len        = LW'(DW + HW);
      end
      default: begin
        frame     = pi_fill ? {pi_data, {DW{1'b0}}} : {{DW{1'b0}}, pi_data};
        frame_len = LW'(FW);
      end
    endcase

    // MSB-first frames are left-aligned so both orders shift out of a fixed end.
    frame_sr = pi_msb ? (frame << (LW'(FW) - frame_len)) : frame;

    // The first bit of a word goes out on the load edge itself, straight from
    // the inputs; later bits come from the latched shift register.
    cur_sr  = (state == ST_IDLE) ? frame_sr : sr;
    cur_msb = (state == ST_IDLE) ? pi_msb : msb_first;
    bit_out = cur_msb ? cur_sr[FW-1] : cur_sr[0];
    next_sr = cur_msb ? (cur_sr << 1) : (cur_sr >> 1);
    emit    = ((state == ST_IDLE) && !pi_end && load) ||
              ((state == ST_SHIFT) && (remaining != '0));

    acc_next  = PW'({acc, bit_out});
    pix_full  = (cnt == CW'(PW - 1));
    flush_pix = acc << (CW'(PW) - cnt);

    // Address of a write issued on this edge: the previous write's address
    // has already been used, so step past it.
    wr_addr = pixel_addr + AW'(pixel_wr);
    wr_last = (wr_addr == '1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      sr            <= '0;
      msb_first     <= 1'b0;
      remaining     <= '0;
      acc           <= '0;
      cnt           <= '0;
      so_data       <= 1'b0;
      so_valid      <= 1'b0;
      pixel_wr      <= 1'b0;
      pixel_addr    <= '0;
      pixel_dataout <= '0;
      pixel_finish  <= 1'b0;
    end else begin
      so_valid   <= 1'b0;
      so_data    <= 1'b0;
      pixel_wr   <= 1'b0;
      pixel_addr <= wr_addr;

      case (state)
        ST_IDLE: begin
          if (pi_end) begin
            pixel_wr <= 1'b1;
            if (cnt != '0) begin
              pixel_dataout <= flush_pix;
              cnt           <= '0;
              state         <= wr_last ? ST_DONE : ST_FLUSH;
            end else begin
              pixel_dataout <= FILL;
              state         <= wr_last ? ST_DONE : ST_FILL;
            end
          end else if (load) begin
            msb_first <= pi_msb;
            remaining <= frame_len - LW'(1);
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (remaining == '0) state <= ST_IDLE;
          else                 remaining <= remaining - LW'(1);
        end
        // FLUSH only labels the cycle showing the flush write; the first
        // fill write is issued on the edge that leaves it.
        ST_FLUSH, ST_FILL: begin
          pixel_wr      <= 1'b1;
          pixel_dataout <= FILL;
          state         <= wr_last ? ST_DONE : ST_FILL;
        end
        default: pixel_finish <= 1'b1;
      endcase

      // Emission overrides the state chosen above when the completing pixel
      // lands on the last address.
      if (emit) begin
        so_valid <= 1'b1;
        so_data  <= bit_out;
        sr       <= next_sr;
        acc      <= acc_next;
        if (pix_full) begin
          pixel_wr      <= 1'b1;
          pixel_dataout <= acc_next;
          cnt           <= '0;
          if (wr_last) state <= ST_DONE;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sti_pixel_packer.sv
// tb_sti_pixel_packer
// Directed bench for sti_pixel_packer. Instance a: DW=16, PW=8, AW=8, FILL=0.
// Instance b: DW=12, PW=8, AW=8, FILL=8'hA7 (word lengths not multiples of
// PW, so partial pixels, carry and flush occur).
module tb_sti_pixel_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic        a_rst, a_load, a_fill, a_msb, a_low, a_end;
  logic [15:0] a_data;
  logic [1:0]  a_len;
  logic        a_busy, a_so_data, a_so_valid, a_wr, a_finish;
  logic [7:0]  a_addr, a_dout;

  logic        b_rst, b_load, b_fill, b_msb, b_low, b_end;
  logic [11:0] b_data;
  logic [1:0]  b_len;
  logic        b_busy, b_so_data, b_so_valid, b_wr, b_finish;
  logic [7:0]  b_addr, b_dout;

  sti_pixel_packer #(.DW(16), .PW(8), .AW(8), .FILL(8'h00)) u_dut_a (
    .clk(clk), .reset(a_rst), .load(a_load), .pi_data(a_data), .pi_length(a_len),
    .pi_fill(a_fill), .pi_msb(a_msb), .pi_low(a_low), .pi_end(a_end),
    .busy(a_busy), .so_data(a_so_data), .so_valid(a_so_valid), .pixel_wr(a_wr),
    .pixel_addr(a_addr), .pixel_dataout(a_dout), .pixel_finish(a_finish)
  );

  sti_pixel_packer #(.DW(12), .PW(8), .AW(8), .FILL(8'hA7)) u_dut_b (
    .clk(clk), .reset(b_rst), .load(b_load), .pi_data(b_data), .pi_length(b_len),
    .pi_fill(b_fill), .pi_msb(b_msb), .pi_low(b_low), .pi_end(b_end),
    .busy(b_busy), .so_data(b_so_data), .so_valid(b_so_valid), .pixel_wr(b_wr),
    .pixel_addr(b_addr), .pixel_dataout(b_dout), .pixel_finish(b_finish)
  );

  typedef struct {
    int unsigned addr;
    int unsigned data;
    int unsigned cyc;
  } wr_t;

  wr_t wq_a[$];
  wr_t wq_b[$];

  always @(negedge clk) begin : mon
    wr_t w;
    if (a_wr) begin
      w.addr = a_addr; w.data = a_dout; w.cyc = cyc;
      wq_a.push_back(w);
    end
    if (b_wr) begin
      w.addr = b_addr; w.data = b_dout; w.cyc = cyc;
      wq_b.push_back(w);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [20:0] outs_a();
    return {a_busy, a_so_data, a_so_valid, a_wr, a_addr, a_dout, a_finish};
  endfunction

  function automatic logic [20:0] outs_b();
    return {b_busy, b_so_data, b_so_valid, b_wr, b_addr, b_dout, b_finish};
  endfunction

  // Issue one word, capture L emitted bits, then check the idle cycle L+1.
  // base: cyc value such that cycle k of the word has cyc == base + k.
  task automatic word(input bit on_b, input logic [1:0] len, input logic [15:0] data,
                      input logic fill, input logic msb, input logic low,
                      input int unsigned l, input logic [31:0] exp_stream,
                      input string tag, output int unsigned base);
    logic [31:0] stream;
    int unsigned nvalid;
    stream = '0;
    nvalid = 0;
    if (on_b) begin
      b_len = len; b_data = data[11:0]; b_fill = fill; b_msb = msb; b_low = low; b_load = 1'b1;
    end else begin
      a_len = len; a_data = data; a_fill = fill; a_msb = msb; a_low = low; a_load = 1'b1;
    end
    base = cyc;
    @(negedge clk);
    a_load = 1'b0;
    b_load = 1'b0;
    for (int unsigned i = 0; i < l; i++) begin
      if (i != 0) @(negedge clk);
      if (on_b) begin
        stream = {stream[30:0], b_so_data}; nvalid += b_so_valid;
      end else begin
        stream = {stream[30:0], a_so_data}; nvalid += a_so_valid;
      end
    end
    @(negedge clk);
    check({tag, "_stream"}, stream, exp_stream);
    check({tag, "_nvalid"}, nvalid, l);
    if (on_b) check({tag, "_idle"}, {b_busy, b_so_valid}, 2'b00);
    else      check({tag, "_idle"}, {a_busy, a_so_valid}, 2'b00);
  endtask

  task automatic expect_pix(input bit on_b, input string tag, input int unsigned addr,
                            input int unsigned data, input int unsigned rel,
                            input int unsigned base);
    wr_t w;
    int  n;
    n = on_b ? wq_b.size() : wq_a.size();
    if (n == 0) begin
      check({tag, "_present"}, n, 1);
      return;
    end
    if (on_b) w = wq_b.pop_front();
    else      w = wq_a.pop_front();
    check({tag, "_addr"}, w.addr, addr);
    check({tag, "_data"}, w.data, data);
    check({tag, "_cyc"}, w.cyc - base, rel);
  endtask

  // Instance b: first write (a0,d0) in cycle 1, then FILL at a0+1.. on consecutive cycles.
  task automatic check_fill_b(input string tag, input int unsigned a0, input int unsigned d0,
                              input int unsigned n, input int unsigned base);
    int unsigned errs;
    wr_t w;
    errs = 0;
    check({tag, "_nwr"}, wq_b.size(), n);
    expect_pix(1'b1, {tag, "_first"}, a0, d0, 1, base);
    for (int unsigned i = 1; i < n; i++) begin
      if (wq_b.size() == 0) begin
        errs++;
        break;
      end
      w = wq_b.pop_front();
      if (w.addr != a0 + i || w.data != 32'hA7 || w.cyc - base != i + 1) errs++;
    end
    check({tag, "_seq"}, errs, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    int unsigned base, first, second, nvalid, fin, errs, exp_d;
    logic        prev;
    logic [31:0] stream;
    wr_t         w;

    a_rst = 1'b1; a_load = 1'b0; a_fill = 1'b0; a_msb = 1'b0; a_low = 1'b0; a_end = 1'b0;
    a_data = '0; a_len = '0;
    b_rst = 1'b1; b_load = 1'b0; b_fill = 1'b0; b_msb = 1'b0; b_low = 1'b0; b_end = 1'b0;
    b_data = '0; b_len = '0;

    repeat (3) @(negedge clk);
    check("a_reset_outs", outs_a(), 0);
    check("b_reset_outs", outs_b(), 0);
    a_rst = 1'b0;
    @(negedge clk);

    // ---------------- instance a: word formats ----------------
    word(1'b0, 2'b01, 16'hA53C, 1'b0, 1'b1, 1'b0, 16, 32'hA53C, "a53c", base);
    check("a53c_nwr", wq_a.size(), 2);
    expect_pix(1'b0, "a53c_p0", 0, 8'hA5, 8, base);
    expect_pix(1'b0, "a53c_p1", 1, 8'h3C, 16, base);

    word(1'b0, 2'b00, 16'h13FF, 1'b0, 1'b0, 1'b1, 8, 32'hC8, "hi_lsb", base);
    expect_pix(1'b0, "hi_lsb_p", 2, 8'hC8, 8, base);

    word(1'b0, 2'b00, 16'hABCD, 1'b0, 1'b1, 1'b0, 8, 32'hCD, "lo_msb", base);
    expect_pix(1'b0, "lo_msb_p", 3, 8'hCD, 8, base);

    word(1'b0, 2'b10, 16'hFFFF, 1'b0, 1'b1, 1'b0, 24, 32'h00FFFF, "l10_right", base);
    expect_pix(1'b0, "l10_right_p0", 4, 8'h00, 8, base);
    expect_pix(1'b0, "l10_right_p1", 5, 8'hFF, 16, base);
    expect_pix(1'b0, "l10_right_p2", 6, 8'hFF, 24, base);

    word(1'b0, 2'b10, 16'hFFFF, 1'b1, 1'b1, 1'b0, 24, 32'hFFFF00, "l10_left", base);
    expect_pix(1'b0, "l10_left_p0", 7, 8'hFF, 8, base);
    expect_pix(1'b0, "l10_left_p1", 8, 8'hFF, 16, base);
    expect_pix(1'b0, "l10_left_p2", 9, 8'h00, 24, base);

    // W = 32'h12340000 sent LSB first: bit-reversed order is 32'h00002C48
    word(1'b0, 2'b11, 16'h1234, 1'b1, 1'b0, 1'b0, 32, 32'h00002C48, "l11_lsb", base);
    expect_pix(1'b0, "l11_lsb_p0", 10, 8'h00, 8, base);
    expect_pix(1'b0, "l11_lsb_p1", 11, 8'h00, 16, base);
    expect_pix(1'b0, "l11_lsb_p2", 12, 8'h2C, 24, base);
    expect_pix(1'b0, "l11_lsb_p3", 13, 8'h48, 32, base);

    // ---------------- load held high: one word per L+1 cycles ----------------
    a_len = 2'b00; a_data = 16'h00F0; a_low = 1'b0; a_msb = 1'b1; a_load = 1'b1;
    base = cyc; first = 0; second = 0; nvalid = 0; prev = 1'b0;
    for (int unsigned c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 18) a_load = 1'b0;
      if (a_so_valid && !prev) begin
        if (first == 0) first = c;
        else if (second == 0) second = c;
      end
      prev = a_so_valid;
      nvalid += a_so_valid;
    end
    check("tput_first", first, 1);
    check("tput_gap", second - first, 9);
    check("tput_nvalid", nvalid, 16);
    expect_pix(1'b0, "tput_p0", 14, 8'hF0, 8, base);
    expect_pix(1'b0, "tput_p1", 15, 8'hF0, 17, base);

    // ---------------- load pulse while busy is dropped ----------------
    a_len = 2'b01; a_data = 16'h0F0F; a_msb = 1'b1; a_load = 1'b1;
    base = cyc; nvalid = 0; stream = '0;
    for (int unsigned c = 1; c <= 20; c++) begin
      @(negedge clk);
      a_load = (c == 5);
      if (c == 5) a_data = 16'hFFFF;
      if (a_so_valid) stream = {stream[30:0], a_so_data};
      nvalid += a_so_valid;
    end
    a_load = 1'b0;
    check("busy_load_stream", stream, 32'h0F0F);
    check("busy_load_nvalid", nvalid, 16);
    expect_pix(1'b0, "busy_load_p0", 16, 8'h0F, 8, base);
    expect_pix(1'b0, "busy_load_p1", 17, 8'h0F, 16, base);

    // ---------------- asynchronous reset mid-word ----------------
    a_len = 2'b01; a_data = 16'hF00F; a_msb = 1'b1; a_load = 1'b1;
    base = cyc;
    @(negedge clk);
    a_load = 1'b0;
    repeat (11) @(negedge clk);
    check("pre_rst_state", {a_so_valid, a_busy, a_addr, a_dout}, {1'b1, 1'b1, 8'd19, 8'hF0});
    expect_pix(1'b0, "pre_rst_p", 18, 8'hF0, 8, base);
    #2 a_rst = 1'b1;
    #1 check("async_rst_outs", outs_a(), 0);
    @(negedge clk);
    a_rst = 1'b0;
    @(negedge clk);

    // ---------------- 128 words fill the memory without pi_end ----------------
    wq_a.delete();
    for (int unsigned n = 0; n < 127; n++) begin
      a_len = 2'b01; a_msb = 1'b1; a_data = {n[7:0], n[7:0] ^ 8'h5A}; a_load = 1'b1;
      @(negedge clk);
      a_load = 1'b0;
      repeat (16) @(negedge clk);
    end
    a_data = {8'd127, 8'd127 ^ 8'h5A}; a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    repeat (15) @(negedge clk);
    check("last_wr_addr", {a_wr, a_addr}, {1'b1, 8'hFF});
    check("finish_before_last", a_finish, 1'b0);
    @(negedge clk);
    check("finish_after_last", a_finish, 1'b1);
    check("done_busy", a_busy, 1'b1);
    check("fill128_nwr", wq_a.size(), 256);
    errs = 0;
    for (int unsigned i = 0; i < 256; i++) begin
      if (wq_a.size() == 0) begin
        errs++;
        break;
      end
      w = wq_a.pop_front();
      exp_d = (i % 2 == 0) ? (i / 2) : ((i / 2) ^ 32'h5A);
      if (w.addr != i || w.data != exp_d) errs++;
    end
    check("fill128_seq", errs, 0);

    a_data = 16'hFFFF; a_len = 2'b01; a_load = 1'b1; a_end = 1'b1; nvalid = 0;
    repeat (20) begin
      @(negedge clk);
      nvalid += a_so_valid;
    end
    a_load = 1'b0; a_end = 1'b0;
    check("done_load_nvalid", nvalid, 0);
    check("done_load_nwr", wq_a.size(), 0);
    check("done_finish_sticky", a_finish, 1'b1);

    // ---------------- instance b: carry across words, flush, fill ----------------
    b_rst = 1'b0;
    @(negedge clk);
    word(1'b1, 2'b01, 16'h0ABC, 1'b0, 1'b1, 1'b0, 12, 32'hABC, "b_w12", base);
    expect_pix(1'b1, "b_w12_p", 0, 8'hAB, 8, base);
    // carried 4'hC plus the first four bits of 6'b100011
    word(1'b1, 2'b00, 16'h0123, 1'b0, 1'b1, 1'b0, 6, 32'h23, "b_w6", base);
    expect_pix(1'b1, "b_w6_p", 1, 8'hC8, 4, base);

    b_end = 1'b1;
    base = cyc; fin = 0;
    for (int unsigned c = 1; c <= 300; c++) begin
      @(negedge clk);
      b_end = 1'b0;
      if (c == 1) check("b_carry_flush_busy", b_busy, 1'b1);
      if (b_finish && fin == 0) fin = c;
    end
    check("b_carry_finish_cyc", fin, 255);
    check_fill_b("b_carry_fill", 2, 8'hC0, 254, base);

    b_rst = 1'b1;
    #1 check("b_rst_from_done", outs_b(), 0);
    @(negedge clk);
    b_rst = 1'b0;

    word(1'b1, 2'b00, 16'h0FC0, 1'b0, 1'b1, 1'b1, 6, 32'h3F, "b_fc0", base);
    check("b_fc0_nowr", wq_b.size(), 0);

    // pi_end and load together: pi_end wins, no serial output follows
    b_end = 1'b1; b_load = 1'b1; b_len = 2'b01; b_data = 12'hFFF;
    base = cyc; fin = 0; nvalid = 0;
    for (int unsigned c = 1; c <= 300; c++) begin
      @(negedge clk);
      b_end = 1'b0;
      b_load = 1'b0;
      nvalid += b_so_valid;
      if (c == 256) check("b_finish_at_last_wr", {b_wr, b_addr, b_finish}, {1'b1, 8'hFF, 1'b0});
      if (b_finish && fin == 0) fin = c;
    end
    check("b_end_nvalid", nvalid, 0);
    check("b_finish_cyc", fin, 257);
    check_fill_b("b_flush_fill", 0, 8'hFC, 256, base);

    b_load = 1'b1; b_data = 12'hABC; nvalid = 0;
    repeat (10) begin
      @(negedge clk);
      nvalid += b_so_valid;
    end
    b_load = 1'b0;
    check("b_done_load_nvalid", nvalid, 0);
    check("b_done_load_nwr", wq_b.size(), 0);
    check("b_done_finish", b_finish, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
